// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID register for the MINI-RISC pipeline.
// Sequences the PC, handshakes with instruction memory, absorbs stalls in a one-entry skid buffer.
module fetch_unit #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   inc_pc,
  input  logic                   jump,
  input  logic                   branch_en,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [PC_WIDTH-1:0]    id_pc,
  output logic                   id_valid,
  output logic [4:0]             opcode,
  output logic [3:0]             flag_index,
  output logic                   halted
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]             state, state_n;
  logic [PC_WIDTH-1:0]    pc, pc_n;
  logic [INSTR_WIDTH-1:0] id_instr_n;
  logic [PC_WIDTH-1:0]    id_pc_n;
  logic                   id_valid_n;
  logic [INSTR_WIDTH-1:0] skid_instr, skid_instr_n;
  logic [PC_WIDTH-1:0]    skid_pc, skid_pc_n;
  logic                   skid_full, skid_full_n;
  logic                   discard, discard_n;
  logic                   redirect;
  logic                   halt_req;
  logic [PC_WIDTH-1:0]    pc_inc;

  assign redirect = id_valid & jump & branch_en;
  assign halt_req = id_valid & ~inc_pc & ~jump & ~stall;
  assign pc_inc   = pc + PC_WIDTH'(1);

  assign imem_req   = (state == S_FETCH) & ~rst;
  assign imem_addr  = pc;
  assign halted     = (state == S_HALTED) & ~rst;
  assign opcode     = id_instr[15:11];
  assign flag_index = id_instr[3:0];

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    id_instr_n   = id_instr;
    id_pc_n      = id_pc;
    id_valid_n   = id_valid;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    skid_full_n  = skid_full;
    discard_n    = discard;

    if (state == S_HALTED) begin
      state_n = S_HALTED;
    end else if (redirect) begin
      // A taken branch kills everything younger than ID, stall or not.
      pc_n        = branch_target;
      id_valid_n  = 1'b0;
      skid_full_n = 1'b0;
      if ((state == S_WAIT) && !imem_rvalid) begin
        discard_n = 1'b1;
        state_n   = S_WAIT;
      end else begin
        discard_n = 1'b0;
        state_n   = S_FETCH;
      end
    end else if (halt_req) begin
      state_n     = S_HALTED;
      discard_n   = 1'b0;
      skid_full_n = 1'b0;
    end else begin
      if (!stall) begin
        id_valid_n = 1'b0;
      end
      case (state)
        S_FETCH: begin
          if (imem_gnt) begin
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard_n = 1'b0;
              state_n   = S_FETCH;
            end else if (!stall) begin
              id_instr_n = imem_rdata;
              id_pc_n    = pc;
              id_valid_n = 1'b1;
              pc_n       = pc_inc;
              state_n    = S_FETCH;
            end else begin
              skid_instr_n = imem_rdata;
              skid_pc_n    = pc;
              skid_full_n  = 1'b1;
              pc_n         = pc_inc;
              state_n      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            id_instr_n  = skid_instr;
            id_pc_n     = skid_pc;
            id_valid_n  = skid_full;
            skid_full_n = 1'b0;
            state_n     = S_FETCH;
          end
        end
        default: begin
          state_n = S_FETCH;
        end
      endcase
    end
  end

  // IF/ID register and fetch control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      id_instr  <= '0;
      id_pc     <= '0;
      id_valid  <= 1'b0;
      skid_full <= 1'b0;
      discard   <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      id_instr  <= id_instr_n;
      id_pc     <= id_pc_n;
      id_valid  <= id_valid_n;
      skid_full <= skid_full_n;
      discard   <= discard_n;
    end
  end

  // Skid payload only matters while skid_full is set
  always_ff @(posedge clk) begin
    skid_instr <= skid_instr_n;
    skid_pc    <= skid_pc_n;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle vectors for fetch/stall/redirect/halt,
// plus reset, halt-hold and wrap-around sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [15:0] imem_addr, imem_rdata;
  logic        stall, inc_pc, jump, branch_en;
  logic [15:0] branch_target;
  logic [15:0] id_instr, id_pc;
  logic        id_valid, halted;
  logic [4:0]  opcode;
  logic [3:0]  flag_index;

  logic        imem_req2, imem_gnt2, imem_rvalid2;
  logic [15:0] imem_addr2, imem_rdata2;
  logic        stall2, inc_pc2, jump2, branch_en2;
  logic [15:0] branch_target2;
  logic [15:0] id_instr2, id_pc2;
  logic        id_valid2, halted2;
  logic [4:0]  opcode2;
  logic [3:0]  flag_index2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .inc_pc(inc_pc), .jump(jump), .branch_en(branch_en),
    .branch_target(branch_target),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
    .opcode(opcode), .flag_index(flag_index), .halted(halted)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .stall(stall2), .inc_pc(inc_pc2), .jump(jump2), .branch_en(branch_en2),
    .branch_target(branch_target2),
    .id_instr(id_instr2), .id_pc(id_pc2), .id_valid(id_valid2),
    .opcode(opcode2), .flag_index(flag_index2), .halted(halted2)
  );

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [15:0] rd;
    logic        st;
    logic        inc;
    logic        jp;
    logic        be;
    logic [15:0] tg;
    logic        ereq;
    logic [15:0] eaddr;
    logic        eidv;
    logic        cid;
    logic [15:0] epc;
    logic [15:0] einstr;
    logic        ehalt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic g, input logic rv, input logic [15:0] rd,
                              input logic st, input logic inc, input logic jp,
                              input logic be, input logic [15:0] tg,
                              input logic ereq, input logic [15:0] eaddr,
                              input logic eidv, input logic cid,
                              input logic [15:0] epc, input logic [15:0] einstr,
                              input logic ehalt);
    vec_t v;
    v.gnt = g; v.rv = rv; v.rd = rd; v.st = st; v.inc = inc; v.jp = jp;
    v.be = be; v.tg = tg; v.ereq = ereq; v.eaddr = eaddr; v.eidv = eidv;
    v.cid = cid; v.epc = epc; v.einstr = einstr; v.ehalt = ehalt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    stall = 1'b0; inc_pc = 1'b1; jump = 1'b0; branch_en = 1'b0;
    branch_target = 16'h0000;
  endtask

  task automatic apply(input int i, input vec_t v);
    logic [15:0] ei;
    @(negedge clk);
    imem_gnt = v.gnt; imem_rvalid = v.rv; imem_rdata = v.rd;
    stall = v.st; inc_pc = v.inc; jump = v.jp; branch_en = v.be;
    branch_target = v.tg;
    #1;
    ei = v.einstr;
    check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, v.ereq});
    if (v.ereq) check($sformatf("v%0d_addr", i), {16'd0, imem_addr}, {16'd0, v.eaddr});
    check($sformatf("v%0d_id_valid", i), {31'd0, id_valid}, {31'd0, v.eidv});
    check($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, v.ehalt});
    if (v.cid) begin
      check($sformatf("v%0d_id_pc", i), {16'd0, id_pc}, {16'd0, v.epc});
      check($sformatf("v%0d_id_instr", i), {16'd0, id_instr}, {16'd0, ei});
      check($sformatf("v%0d_opcode", i), {27'd0, opcode}, {27'd0, ei[15:11]});
      check($sformatf("v%0d_flag", i), {28'd0, flag_index}, {28'd0, ei[3:0]});
    end
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    imem_gnt2 = 1'b0; imem_rvalid2 = 1'b0; imem_rdata2 = 16'h0000;
    stall2 = 1'b0; inc_pc2 = 1'b1; jump2 = 1'b0; branch_en2 = 1'b0;
    branch_target2 = 16'h0000;

    //        gnt rv  rdata    st inc jp be target    req addr     idv cid id_pc    id_instr halt
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 16'h0800, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0001, 1, 1, 16'h0000, 16'h0800, 0));
    vecs.push_back(mk(0, 1, 16'h1000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'h0001, 16'h1000, 0));
    vecs.push_back(mk(0, 1, 16'h1800, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0003, 1, 1, 16'h0002, 16'h1800, 0));
    // stray rvalid in FETCH, then address held until granted
    vecs.push_back(mk(0, 1, 16'hFFFF, 0, 1, 0, 0, 16'h0000, 1, 16'h0003, 0, 1, 16'h0002, 16'h1800, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0003, 0, 1, 16'h0002, 16'h1800, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 16'h2000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0004, 1, 1, 16'h0003, 16'h2000, 0));
    vecs.push_back(mk(0, 1, 16'h2805, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0005, 1, 1, 16'h0004, 16'h2805, 0));
    // stall while addr 5 returns: skid holds it, no request
    vecs.push_back(mk(0, 1, 16'h3000, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0004, 16'h2805, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0004, 16'h2805, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0004, 16'h2805, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0004, 16'h2805, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0006, 1, 1, 16'h0005, 16'h3000, 0));
    vecs.push_back(mk(0, 1, 16'h3800, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0007, 1, 1, 16'h0006, 16'h3800, 0));
    vecs.push_back(mk(0, 1, 16'h4000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    // grant addr 8 with ID held by stall, then taken branch while WAIT
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 1, 16'h0008, 1, 1, 16'h0007, 16'h4000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 1, 16'h0040, 0, 16'h0000, 1, 1, 16'h0007, 16'h4000, 0));
    vecs.push_back(mk(0, 1, 16'h4800, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0007, 16'h4000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0040, 0, 1, 16'h0007, 16'h4000, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 16'h5000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    // fill skid under stall, then redirect while still stalled
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 1, 16'h0041, 1, 1, 16'h0040, 16'h5000, 0));
    vecs.push_back(mk(0, 1, 16'h5800, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0040, 16'h5000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 1, 16'h0100, 0, 16'h0000, 1, 1, 16'h0040, 16'h5000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0100, 0, 1, 16'h0040, 16'h5000, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 16'h6000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    // HALT in ID
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 16'h0101, 1, 1, 16'h0100, 16'h6000, 0));

    // reset sequence, with an rvalid in the first cycle after reset
    @(negedge clk);
    rst = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 16'hF800;
    @(negedge clk);
    #1;
    check("rst_req_low", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 16'hF800;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", {16'd0, imem_addr}, 32'h0000);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_pc", {16'd0, id_pc}, 32'h0000);
    check("rst_id_instr", {16'd0, id_instr}, 32'h0000);
    check("rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    check("post_rst_rvalid_idv", {31'd0, id_valid}, 32'd0);
    check("post_rst_rvalid_instr", {16'd0, id_instr}, 32'h0000);
    check("post_rst_rvalid_addr", {16'd0, imem_addr}, 32'h0000);

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // HALTED must ignore everything but reset
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      imem_gnt = 1'b1; imem_rvalid = c[0]; imem_rdata = 16'h7000;
      stall = c[1]; inc_pc = 1'b1; jump = c[2]; branch_en = c[2];
      branch_target = 16'h0200;
      #1;
      check($sformatf("halt%0d_req", c), {31'd0, imem_req}, 32'd0);
      check($sformatf("halt%0d_halted", c), {31'd0, halted}, 32'd1);
      check($sformatf("halt%0d_id_pc", c), {16'd0, id_pc}, 32'h0100);
      check($sformatf("halt%0d_id_instr", c), {16'd0, id_instr}, 32'h6000);
    end

    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_gnt = 1'b1;
    imem_gnt2 = 1'b1;
    #1;
    check("rehalt_req", {31'd0, imem_req}, 32'd1);
    check("rehalt_addr", {16'd0, imem_addr}, 32'h0000);
    check("rehalt_halted", {31'd0, halted}, 32'd0);
    check("rehalt_idv", {31'd0, id_valid}, 32'd0);
    check("wrap_req0", {31'd0, imem_req2}, 32'd1);
    check("wrap_addr0", {16'd0, imem_addr2}, 32'hFFFF);
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h0800;
    imem_gnt2 = 1'b0; imem_rvalid2 = 1'b1; imem_rdata2 = 16'h0801;
    #1;
    check("wrap_req_wait", {31'd0, imem_req2}, 32'd0);
    @(negedge clk);
    drive_idle();
    imem_rvalid2 = 1'b0;
    #1;
    check("resume_idv", {31'd0, id_valid}, 32'd1);
    check("resume_id_pc", {16'd0, id_pc}, 32'h0000);
    check("resume_addr", {16'd0, imem_addr}, 32'h0001);
    check("wrap_addr1", {16'd0, imem_addr2}, 32'h0000);
    check("wrap_req1", {31'd0, imem_req2}, 32'd1);
    check("wrap_idv", {31'd0, id_valid2}, 32'd1);
    check("wrap_id_pc", {16'd0, id_pc2}, 32'hFFFF);
    check("wrap_id_instr", {16'd0, id_instr2}, 32'h0801);
    check("wrap_opcode", {27'd0, opcode2}, 32'd1);
    check("wrap_flag", {28'd0, flag_index2}, 32'd1);
    check("wrap_halted", {31'd0, halted2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
